// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier:
// Booth select codes, FSM state encoding and the counter width helper.
package booth_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] SEL_ZERO_LO = 3'b000;
  localparam logic [2:0] SEL_P1_A    = 3'b001;
  localparam logic [2:0] SEL_P1_B    = 3'b010;
  localparam logic [2:0] SEL_P2      = 3'b011;
  localparam logic [2:0] SEL_M2      = 3'b100;
  localparam logic [2:0] SEL_M1_A    = 3'b101;
  localparam logic [2:0] SEL_M1_B    = 3'b110;
  localparam logic [2:0] SEL_ZERO_HI = 3'b111;

  // 2'd3 is never entered; the FSM default branch steers it back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } booth_state_e;

  function automatic int booth_cnt_w(input int width);
    return (width / 2 <= 2) ? 1 : $clog2(width / 2);
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational radix-4 Booth partial-product generator. The multiplicand
// arrives already sign-extended and shifted, so the result is sign-correct.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [2:0]         sel,
  output logic [2*WIDTH-1:0] pp
);

  localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] mcand_x2;

  // Working at full product width keeps -2X of the most-negative operand exact.
  assign mcand_x2 = {mcand[2*WIDTH-2:0], 1'b0};

  always_comb begin
    pp = '0;
    case (sel)
      SEL_P1_A, SEL_P1_B: pp = mcand;
      SEL_P2:             pp = mcand_x2;
      SEL_M2:             pp = ~mcand_x2 + ONE;
      SEL_M1_A, SEL_M1_B: pp = ~mcand + ONE;
      default:            pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier: two multiplier bits per cycle,
// WIDTH/2 accumulate cycles, full 2*WIDTH signed product.
module booth_seq_multiplier
  import booth_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int ITER  = WIDTH / 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output booth_state_e         dbg_state
);

  localparam int            CW   = booth_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  // Handshakes: operands are taken on a rising edge with in_valid && in_ready;
  // the product is handed off on a rising edge with out_valid && out_ready.

  booth_state_e         state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]       mplr_q, mplr_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0]   pp;
  logic [2*WIDTH-1:0]   acc_sum;

  booth_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
    .mcand (mcand_q),
    .sel   (mplr_q[2:0]),
    .pp    (pp)
  );

  assign acc_sum   = acc_q + pp;
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplr_d      = mplr_q;
    acc_d       = acc_q;
    count_d     = count_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mcand_d = {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
          mplr_d  = {multiplier, 1'b0};
          acc_d   = '0;
          count_d = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d   = acc_sum;
        mcand_d = {mcand_q[2*WIDTH-3:0], 2'b00};
        mplr_d  = {{2{mplr_q[WIDTH]}}, mplr_q[WIDTH:2]};
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          product_d   = acc_sum;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mcand_q     <= '0;
      mplr_q      <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplr_q      <= mplr_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed bench for booth_seq_multiplier: latency, signed and corner
// products, backpressure, mid-operation reset and a short random sweep.
module tb_booth_seq_multiplier;
  import booth_pkg::*;

  localparam int W = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     mcand_i;
  logic [W-1:0]     mplr_i;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   product;
  booth_state_e     dbg_state;

  int total = 0;
  int bad   = 0;

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (mcand_i),
    .multiplier   (mplr_i),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one operand pair, then waits (bounded) for out_valid.
  task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output logic [2*W-1:0] prod,
                          output logic ready_seen);
    @(negedge clk);
    in_valid = 1'b1;
    mcand_i  = x;
    mplr_i   = y;
    @(negedge clk);
    in_valid   = 1'b0;
    lat        = 0;
    ready_seen = in_ready;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!out_valid) ready_seen = ready_seen | in_ready;
    end
    prod = product;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    total++;
    if (product !== '0) begin
      bad++; $display("FAIL reset_product: got %h want 0", product);
    end
    total++;
    if (dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int lat; logic [2*W-1:0] p; logic rs;
    drive_op(32'd3, 32'd5, lat, p, rs);
    total++;
    if (lat !== 16) begin
      bad++; $display("FAIL basic_latency: got %0d want 16", lat);
    end
    total++;
    if (p !== 64'd15) begin
      bad++; $display("FAIL basic_product: got %h want %h", p, 64'd15);
    end
    total++;
    if (rs !== 1'b0) begin
      bad++; $display("FAIL basic_busy_ready: got %b want 0", rs);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL basic_done_ready: got %b want 0", in_ready);
    end
    finish_op();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL basic_handoff: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    total++;
    if (product !== 64'd15) begin
      bad++; $display("FAIL basic_hold: got %h want %h", product, 64'd15);
    end
  endtask

  task automatic test_signed();
    int lat; logic [2*W-1:0] p; logic rs;
    drive_op(32'hFFFF_FFF9, 32'd6, lat, p, rs);
    total++;
    if (p !== 64'hFFFF_FFFF_FFFF_FFD6 || lat !== 16) begin
      bad++; $display("FAIL signed_m7x6: got %h lat %0d want %h lat 16", p, lat, 64'hFFFF_FFFF_FFFF_FFD6);
    end
    finish_op();
    drive_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, lat, p, rs);
    total++;
    if (p !== 64'h3FFF_FFFF_0000_0001) begin
      bad++; $display("FAIL signed_maxpos: got %h want %h", p, 64'h3FFF_FFFF_0000_0001);
    end
    finish_op();
  endtask

  task automatic test_corner();
    int lat; logic [2*W-1:0] p; logic rs;
    drive_op(32'h8000_0000, 32'h8000_0000, lat, p, rs);
    total++;
    if (p !== 64'h4000_0000_0000_0000) begin
      bad++; $display("FAIL corner_minxmin: got %h want %h", p, 64'h4000_0000_0000_0000);
    end
    finish_op();
    drive_op(32'h8000_0000, 32'hFFFF_FFFF, lat, p, rs);
    total++;
    if (p !== 64'h0000_0000_8000_0000) begin
      bad++; $display("FAIL corner_minxm1: got %h want %h", p, 64'h0000_0000_8000_0000);
    end
    finish_op();
  endtask

  task automatic test_backpressure();
    int lat; logic [2*W-1:0] p; logic rs;
    logic [2*W-1:0] exp_p;
    exp_p = 64'hFFFF_FFFF_FF80_490A;
    drive_op(32'd12345, 32'hFFFF_FD5A, lat, p, rs);
    total++;
    if (p !== exp_p) begin
      bad++; $display("FAIL bp_product: got %h want %h", p, exp_p);
    end
    in_valid = 1'b1;
    mcand_i  = 32'd9;
    mplr_i   = 32'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== exp_p) begin
        bad++;
        $display("FAIL bp_stall_%0d: got valid=%b ready=%b prod=%h want 1/0/%h",
                 i, out_valid, in_ready, product, exp_p);
      end
    end
    in_valid = 1'b0;
    finish_op();
    total++;
    if (dbg_state !== ST_IDLE || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release: got state=%0d ready=%b want 0/1", dbg_state, in_ready);
    end
    drive_op(32'd100, 32'd100, lat, p, rs);
    total++;
    if (p !== 64'h2710 || lat !== 16) begin
      bad++; $display("FAIL bp_next_op: got %h lat %0d want %h lat 16", p, lat, 64'h2710);
    end
    finish_op();
  endtask

  task automatic test_reset_mid();
    int lat; logic [2*W-1:0] p; logic rs;
    @(negedge clk);
    in_valid = 1'b1;
    mcand_i  = 32'd5;
    mplr_i   = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    total++;
    if (dbg_state !== ST_BUSY) begin
      bad++; $display("FAIL rmid_busy: got %0d want 1", dbg_state);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || product !== '0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rmid_async: got valid=%b prod=%h ready=%b want 0/0/1", out_valid, product, in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL rmid_release: got ready=%b state=%0d want 1/0", in_ready, dbg_state);
    end
    drive_op(32'd2, 32'hFFFF_FFFD, lat, p, rs);
    total++;
    if (p !== 64'hFFFF_FFFF_FFFF_FFFA || lat !== 16) begin
      bad++; $display("FAIL rmid_next_op: got %h lat %0d want %h lat 16", p, lat, 64'hFFFF_FFFF_FFFF_FFFA);
    end
    finish_op();
  endtask

  task automatic test_random();
    int lat; logic [2*W-1:0] p; logic rs;
    logic signed [W-1:0]   sx, sy;
    logic signed [2*W-1:0] e;
    int stall;
    for (int i = 0; i < 20; i++) begin
      sx = $urandom;
      sy = $urandom;
      e  = sx * sy;
      drive_op(sx, sy, lat, p, rs);
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      total++;
      if (p !== e || product !== e || lat !== 16) begin
        bad++;
        $display("FAIL rand_%0d: %h*%h got %h (held %h) lat %0d want %h lat 16",
                 i, sx, sy, p, product, lat, e);
      end
      finish_op();
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mcand_i   = '0;
    mplr_i    = '0;
    #12;
    test_reset();
    test_basic();
    test_signed();
    test_corner();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
